// File: rtl/slide_advance_ctrl_pkg.sv
// Shared types and helpers for the slide-advance controller.
//   slide_state_t  : controller FSM states
//   next_image()   : rotation successor with wrap at the image count
package slide_advance_ctrl_pkg;

    localparam int unsigned DEFAULT_NUM_IMAGES = 4;
    localparam int unsigned DEFAULT_INDEX_W    = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        REQ     = 2'd2,
        DROP    = 2'd3
    } slide_state_t;

    // Successor of cur in a rotation of num images (num need not be a power of 2).
    function automatic int unsigned next_image(input int unsigned cur, input int unsigned num);
        return (cur >= num - 32'd1) ? 32'd0 : cur + 32'd1;
    endfunction

endpackage

// File: rtl/slide_advance_ctrl_if.sv
// Loader fetch channel, 4-phase req/ack.
//   load_req   : request, raised by the controller
//   load_index : image index requested, stable while load_req=1
//   load_ack   : acknowledge from the image loader
interface slide_advance_ctrl_if #(
    parameter int unsigned INDEX_W = 2
);
    logic               load_req;
    logic               load_ack;
    logic [INDEX_W-1:0] load_index;

    modport master (output load_req, output load_index, input load_ack);
    modport slave  (input load_req, input load_index, output load_ack);
endinterface

// File: rtl/slide_advance_ctrl_rise_detect.sv
// Registered rising-edge detector with enable.
//   clock, reset : clock, async active-low reset
//   enable       : gates the detected edge
//   din          : level input
//   rise_c       : combinational pulse, din high now and low last cycle
module slide_advance_ctrl_rise_detect (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic din,
    output logic rise_c
);
    logic din_d;

    // Previous-cycle copy of the input, updated every cycle regardless of enable.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) din_d <= 1'b0;
        else        din_d <= din;
    end

    assign rise_c = din & ~din_d & enable;
endmodule

// File: rtl/slide_advance_ctrl.sv
// Slide-advance controller: turns timer advance edges into frame-aligned image fetches.
//   clock, reset   : clock, async active-low reset
//   select         : enable; low drops a waiting request and blocks new edges
//   advance        : advance strobe (level), rising edge counts
//   vsync_start    : one-cycle frame-boundary pulse
//   load_bus       : loader req/ack/index channel (master side)
//   display_index  : image currently shown
//   swap           : one-cycle pulse when display_index updates
//   overrun        : one-cycle pulse when an advance edge is dropped
module slide_advance_ctrl
    import slide_advance_ctrl_pkg::*;
#(
    parameter int unsigned NUM_IMAGES = DEFAULT_NUM_IMAGES,
    parameter int unsigned INDEX_W    = DEFAULT_INDEX_W
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 select,
    input  logic                 advance,
    input  logic                 vsync_start,
    slide_advance_ctrl_if.master load_bus,
    output logic [INDEX_W-1:0]   display_index,
    output logic                 swap,
    output logic                 overrun
);
    slide_state_t       state_q, state_d;
    logic               queued_q, queued_d;
    logic               vs_held_q, vs_held_d;
    logic               load_req_q, load_req_d;
    logic [INDEX_W-1:0] load_index_q, load_index_d;
    logic [INDEX_W-1:0] display_d;
    logic               swap_d, overrun_d;
    logic               rise_c;
    logic [INDEX_W-1:0] next_idx_c;

    slide_advance_ctrl_rise_detect u_rise (
        .clock  (clock),
        .reset  (reset),
        .enable (select),
        .din    (advance),
        .rise_c (rise_c)
    );

    assign next_idx_c = INDEX_W'(next_image(32'(display_index), NUM_IMAGES));

    // Next-state and registered-output values.
    always_comb begin
        state_d      = state_q;
        queued_d     = queued_q;
        vs_held_d    = vs_held_q;
        load_req_d   = load_req_q;
        load_index_d = load_index_q;
        display_d    = display_index;
        swap_d       = 1'b0;
        overrun_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise_c) state_d = PENDING;
            end

            PENDING: begin
                if (!select) begin
                    state_d   = IDLE;
                    vs_held_d = 1'b0;
                end else begin
                    if (rise_c) overrun_d = 1'b1;
                    // A frame boundary seen while the loader still acks is remembered
                    // so the request goes out as soon as ack falls.
                    if ((vsync_start || vs_held_q) && !load_bus.load_ack) begin
                        state_d      = REQ;
                        load_req_d   = 1'b1;
                        load_index_d = next_idx_c;
                        vs_held_d    = 1'b0;
                    end else if (vsync_start) begin
                        vs_held_d = 1'b1;
                    end
                end
            end

            REQ, DROP: begin
                // One advance may queue behind the in-flight fetch.
                if (!select) begin
                    queued_d = 1'b0;
                end else if (rise_c) begin
                    if (queued_q) overrun_d = 1'b1;
                    else          queued_d  = 1'b1;
                end

                if (state_q == REQ) begin
                    if (load_bus.load_ack) begin
                        state_d    = DROP;
                        load_req_d = 1'b0;
                    end
                end else if (!load_bus.load_ack) begin
                    display_d = load_index_q;
                    swap_d    = 1'b1;
                    if (queued_d) begin
                        state_d  = PENDING;
                        queued_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            queued_q      <= 1'b0;
            vs_held_q     <= 1'b0;
            load_req_q    <= 1'b0;
            load_index_q  <= '0;
            display_index <= '0;
            swap          <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            state_q       <= state_d;
            queued_q      <= queued_d;
            vs_held_q     <= vs_held_d;
            load_req_q    <= load_req_d;
            load_index_q  <= load_index_d;
            display_index <= display_d;
            swap          <= swap_d;
            overrun       <= overrun_d;
        end
    end

    assign load_bus.load_req   = load_req_q;
    assign load_bus.load_index = load_index_q;
endmodule

// File: tb/tb_slide_advance_ctrl.sv
// Bench for slide_advance_ctrl: directed scenarios with randomized gaps and loader delays,
// checked against an index-rotation model and a protocol monitor.
module tb_slide_advance_ctrl;
    localparam int unsigned N  = 4;
    localparam int unsigned IW = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          select = 1'b1;
    logic          advance = 1'b0;
    logic          vsync_start = 1'b0;
    logic [IW-1:0] display_index;
    logic          swap;
    logic          overrun;

    slide_advance_ctrl_if #(.INDEX_W(IW)) ld_if ();

    slide_advance_ctrl #(.NUM_IMAGES(N), .INDEX_W(IW)) dut (
        .clock         (clock),
        .reset         (reset),
        .select        (select),
        .advance       (advance),
        .vsync_start   (vsync_start),
        .load_bus      (ld_if),
        .display_index (display_index),
        .swap          (swap),
        .overrun       (overrun)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int swap_cnt = 0;
    int ovr_cnt  = 0;
    int req_cnt  = 0;
    int req_hist[$];
    int swap_hist[$];
    int ack_lo = 1;
    int ack_hi = 3;
    int exp_disp = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic int pop_req();
        if (req_hist.size() == 0) return -1;
        return req_hist.pop_front();
    endfunction

    function automatic int pop_swap();
        if (swap_hist.size() == 0) return -1;
        return swap_hist.pop_front();
    endfunction

    task automatic clear_book();
        swap_cnt = 0;
        ovr_cnt  = 0;
        req_cnt  = 0;
        req_hist.delete();
        swap_hist.delete();
        exp_disp = 0;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        select = 1'b1;
        advance = 1'b0;
        vsync_start = 1'b0;
        step(2);
        chk({tag, "_rst_req"},  ld_if.load_req, 0);
        chk({tag, "_rst_idx"},  ld_if.load_index, 0);
        chk({tag, "_rst_disp"}, display_index, 0);
        chk({tag, "_rst_swap"}, swap, 0);
        chk({tag, "_rst_ovr"},  overrun, 0);
        clear_book();
        reset = 1'b1;
        step(1);
    endtask

    task automatic pulse_adv();
        advance = 1'b1;
        step(1);
        advance = 1'b0;
    endtask

    task automatic pulse_vs();
        vsync_start = 1'b1;
        step(1);
        vsync_start = 1'b0;
    endtask

    task automatic wait_swap(input string tag);
        int start = swap_cnt;
        int k = 0;
        while (swap_cnt == start && k < 200) begin
            step(1);
            k++;
        end
        chk(tag, 32'(swap_cnt > start), 1);
    endtask

    task automatic wait_req(input logic lvl, input string tag);
        int k = 0;
        while (ld_if.load_req !== lvl && k < 100) begin
            step(1);
            k++;
        end
        chk(tag, ld_if.load_req, lvl);
    endtask

    // One full advance -> frame boundary -> fetch -> commit cycle with random spacing.
    task automatic round(input string tag);
        advance = 1'b1;
        step(int'($urandom_range(6, 1)));
        advance = 1'b0;
        step(int'($urandom_range(8, 1)));
        pulse_vs();
        wait_swap({tag, "_swap"});
        exp_disp = (exp_disp + 1) % N;
        chk({tag, "_req_idx"},  pop_req(), exp_disp);
        chk({tag, "_swap_idx"}, pop_swap(), exp_disp);
        chk({tag, "_disp"},     display_index, exp_disp);
    endtask

    // Image loader: follows load_req with a random delay on both phases.
    initial begin : loader
        int wait_left;
        wait_left = 0;
        ld_if.load_ack = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (ld_if.load_req !== ld_if.load_ack) begin
                if (wait_left == 0) wait_left = int'($urandom_range(ack_hi, ack_lo));
                wait_left--;
                if (wait_left == 0) ld_if.load_ack = ld_if.load_req;
            end else begin
                wait_left = 0;
            end
        end
    end

    // Protocol monitor: logs requests and swaps, checks req/ack ordering and index stability.
    initial begin : monitor
        logic          req_prev;
        logic          ack_prev;
        logic [IW-1:0] idx_prev;
        req_prev = 1'b0;
        ack_prev = 1'b0;
        idx_prev = '0;
        forever begin
            @(negedge clock);
            if (reset === 1'b1) begin
                if (swap === 1'b1) begin
                    swap_cnt++;
                    swap_hist.push_back(int'(display_index));
                end
                if (overrun === 1'b1) ovr_cnt++;
                if (ld_if.load_req === 1'b1 && req_prev === 1'b0) begin
                    req_cnt++;
                    req_hist.push_back(int'(ld_if.load_index));
                    chk("req_rise_ack_low", ack_prev, 0);
                end
                if (ld_if.load_req === 1'b1 && req_prev === 1'b1)
                    chk("idx_stable", ld_if.load_index, idx_prev);
            end
            req_prev = ld_if.load_req;
            ack_prev = ld_if.load_ack;
            idx_prev = ld_if.load_index;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin : main
        step(1);

        // 1: single advance held several cycles, fixed loader timing.
        do_reset("t1");
        ack_lo = 2;
        ack_hi = 2;
        advance = 1'b1;
        step(5);
        advance = 1'b0;
        step(5);
        chk("t1_no_early_req", ld_if.load_req, 0);
        pulse_vs();
        chk("t1_req_latency", ld_if.load_req, 1);
        chk("t1_req_idx", ld_if.load_index, 1);
        wait_swap("t1_swap");
        chk("t1_disp", display_index, 1);
        step(3);
        chk("t1_swap_cnt", swap_cnt, 1);
        chk("t1_req_cnt", req_cnt, 1);
        chk("t1_ovr_cnt", ovr_cnt, 0);

        // 2: four rounds wrap 1,2,3,0.
        do_reset("t2");
        ack_lo = 1;
        ack_hi = 3;
        for (int r = 0; r < 4; r++) round($sformatf("t2_r%0d", r));
        chk("t2_swap_cnt", swap_cnt, 4);
        chk("t2_ovr_cnt", ovr_cnt, 0);
        chk("t2_disp_wrap", display_index, 0);

        // 3: advance during REQ queues, advance during DROP overruns.
        do_reset("t3");
        ack_lo = 4;
        ack_hi = 4;
        pulse_adv();
        step(2);
        pulse_vs();
        wait_req(1'b1, "t3_req_up");
        pulse_adv();
        wait_req(1'b0, "t3_req_down");
        pulse_adv();
        chk("t3_ovr_pulse", overrun, 1);
        step(1);
        chk("t3_ovr_single", overrun, 0);
        wait_swap("t3_swap1");
        chk("t3_disp1", display_index, 1);
        chk("t3_ovr_cnt", ovr_cnt, 1);
        step(3);
        chk("t3_wait_vsync", ld_if.load_req, 0);
        pulse_vs();
        chk("t3_queued_req", ld_if.load_req, 1);
        chk("t3_queued_idx", ld_if.load_index, 2);
        wait_swap("t3_swap2");
        chk("t3_disp2", display_index, 2);
        chk("t3_hist1", pop_req(), 1);
        chk("t3_hist2", pop_req(), 2);
        chk("t3_swap_cnt", swap_cnt, 2);

        // 4: select dropped before the frame boundary discards the request.
        do_reset("t4");
        ack_lo = 1;
        ack_hi = 3;
        pulse_adv();
        step(2);
        select = 1'b0;
        step(2);
        pulse_vs();
        step(10);
        chk("t4_no_req", req_cnt, 0);
        chk("t4_req_low", ld_if.load_req, 0);
        chk("t4_disp", display_index, 0);
        select = 1'b1;
        step(1);
        pulse_vs();
        step(5);
        chk("t4_idle_ignores_vs", req_cnt, 0);

        // 5: advance and vsync together -> request only on the next vsync.
        do_reset("t5");
        advance = 1'b1;
        vsync_start = 1'b1;
        step(1);
        advance = 1'b0;
        vsync_start = 1'b0;
        step(4);
        chk("t5_no_req", ld_if.load_req, 0);
        chk("t5_req_cnt", req_cnt, 0);
        pulse_vs();
        chk("t5_req", ld_if.load_req, 1);
        wait_swap("t5_swap");
        chk("t5_disp", display_index, 1);
        chk("t5_req_idx", pop_req(), 1);

        // 6: reset mid-handshake clears immediately; a fresh round restarts at 1.
        pulse_adv();
        step(2);
        pulse_vs();
        wait_req(1'b1, "t6_req_up");
        #2;
        reset = 1'b0;
        #1;
        chk("t6_async_req", ld_if.load_req, 0);
        chk("t6_async_disp", display_index, 0);
        chk("t6_async_swap", swap, 0);
        step(3);
        clear_book();
        reset = 1'b1;
        begin
            int k = 0;
            while (ld_if.load_ack !== 1'b0 && k < 20) begin
                step(1);
                k++;
            end
        end
        chk("t6_ack_idle", ld_if.load_ack, 0);
        round("t6_r");
        chk("t6_req_cnt", req_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
